// File: rtl/alt_vipcto_is2vid_av_st_input.sv
// Avalon-ST video input: decodes packet headers, writes video beats to a FIFO.
// Optional counters are built only when AVST_IN_PACKET_COUNTERS_EN is defined.
//
// Ports:
//   is_clk, rst_n           clock, synchronous active-low reset
//   is_valid/is_data/is_sop/is_eop/is_ready  Avalon-ST sink (ready latency 0)
//   wrreq, wrdata, full     FIFO write side, wrdata = {pixel data, eop}
//   ctrl_width/height/interlace/valid  decoded control packet fields + strobe
//   video_frame_count, discard_count   packet statistics (0 when disabled)
module alt_vipcto_is2vid_av_st_input #(
  parameter int DATA_WIDTH = 20,
  parameter int NUMBER_OF_COLOUR_PLANES_IN_PARALLEL = 2,
  parameter int BPS = 10,
  parameter int FIFO_WIDTH = DATA_WIDTH + 1
) (
  input  logic                  is_clk,
  input  logic                  rst_n,
  input  logic                  is_valid,
  input  logic [DATA_WIDTH-1:0] is_data,
  input  logic                  is_sop,
  input  logic                  is_eop,
  output logic                  is_ready,
  output logic                  wrreq,
  output logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  full,
  output logic [15:0]           ctrl_width,
  output logic [15:0]           ctrl_height,
  output logic [3:0]            ctrl_interlace,
  output logic                  ctrl_valid,
  output logic [15:0]           video_frame_count,
  output logic [15:0]           discard_count
);

  localparam int N = NUMBER_OF_COLOUR_PLANES_IN_PARALLEL;

  typedef enum logic [1:0] {
    IDLE,
    CONTROL,
    VIDEO,
    DISCARD
  } state_t;

  state_t state;

  logic       acc;
  logic       hdr;
  logic       body;
  logic [3:0] pkt_type;

  assign is_ready = (state == VIDEO) ? ~full : 1'b1;
  assign acc      = is_valid & is_ready;
  assign hdr      = acc & is_sop;
  assign body     = acc & ~is_sop;
  assign pkt_type = is_data[3:0];

  // Control symbol decode
  logic [3:0]  sym_cnt;
  logic [3:0]  sym_nx;
  logic [4:0]  sym_sum;
  logic        hit8;
  logic [4:0]  k;
  logic [3:0]  nib;
  logic [15:0] w_sh;
  logic [15:0] h_sh;
  logic [3:0]  il_sh;
  logic [15:0] w_nx;
  logic [15:0] h_nx;
  logic [3:0]  il_nx;

  always_comb begin
    w_nx  = w_sh;
    h_nx  = h_sh;
    il_nx = il_sh;
    k     = '0;
    nib   = '0;
    for (int l = 0; l < N; l++) begin
      k   = {1'b0, sym_cnt} + 5'(l);
      nib = is_data[BPS*l +: 4];
      case (k)
        5'd0:    w_nx[15:12] = nib;
        5'd1:    w_nx[11:8]  = nib;
        5'd2:    w_nx[7:4]   = nib;
        5'd3:    w_nx[3:0]   = nib;
        5'd4:    h_nx[15:12] = nib;
        5'd5:    h_nx[11:8]  = nib;
        5'd6:    h_nx[7:4]   = nib;
        5'd7:    h_nx[3:0]   = nib;
        5'd8:    il_nx       = nib;
        default: ;
      endcase
    end
  end

  // Saturate at 9 so later symbols are ignored and 8 is only hit once
  assign sym_sum = {1'b0, sym_cnt} + 5'(N);
  assign sym_nx  = (sym_sum > 5'd9) ? 4'd9 : sym_sum[3:0];
  assign hit8    = (sym_cnt <= 4'd8) && (sym_sum > 5'd8);

  always_ff @(posedge is_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wrreq          <= 1'b0;
      wrdata         <= '0;
      sym_cnt        <= '0;
      w_sh           <= '0;
      h_sh           <= '0;
      il_sh          <= '0;
      ctrl_width     <= '0;
      ctrl_height    <= '0;
      ctrl_interlace <= '0;
      ctrl_valid     <= 1'b0;
    end else begin
      wrreq      <= 1'b0;
      ctrl_valid <= 1'b0;
      if (hdr) begin
        sym_cnt <= '0;
        if (is_eop) begin
          state <= IDLE;
        end else begin
          unique case (1'b1)
            (pkt_type == 4'h0): state <= VIDEO;
            (pkt_type == 4'hF): state <= CONTROL;
            default:            state <= DISCARD;
          endcase
        end
      end else if (body) begin
        unique case (state)
          IDLE: ;
          VIDEO: begin
            wrreq  <= 1'b1;
            wrdata <= FIFO_WIDTH'({is_data, is_eop});
            if (is_eop)
              state <= IDLE;
          end
          CONTROL: begin
            sym_cnt <= sym_nx;
            w_sh    <= w_nx;
            h_sh    <= h_nx;
            il_sh   <= il_nx;
            if (hit8) begin
              ctrl_width     <= w_nx;
              ctrl_height    <= h_nx;
              ctrl_interlace <= il_nx;
              ctrl_valid     <= 1'b1;
            end
            if (is_eop)
              state <= IDLE;
          end
          DISCARD: begin
            if (is_eop)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AVST_IN_PACKET_COUNTERS_EN
  logic [15:0] vf_cnt;
  logic [15:0] dc_cnt;
  logic        vf_ev;
  logic        ab_ev;
  logic        de_ev;

  assign vf_ev = body & is_eop & (state == VIDEO);
  assign ab_ev = hdr & (state != IDLE);
  assign de_ev = hdr & ~is_eop &
                 (pkt_type != 4'h0) & (pkt_type != 4'hF);

  always_ff @(posedge is_clk) begin
    if (!rst_n) begin
      vf_cnt <= '0;
      dc_cnt <= '0;
    end else begin
      vf_cnt <= vf_cnt + 16'(vf_ev);
      dc_cnt <= dc_cnt + 16'(ab_ev) + 16'(de_ev);
    end
  end

  assign video_frame_count = vf_cnt;
  assign discard_count     = dc_cnt;
`else
  assign video_frame_count = '0;
  assign discard_count     = '0;
`endif

endmodule

// File: tb/tb_alt_vipcto_is2vid_av_st_input.sv
// Directed bench for alt_vipcto_is2vid_av_st_input (N=2, BPS=10).
// Inputs change on the falling edge, outputs are checked on the falling edge.
module tb_alt_vipcto_is2vid_av_st_input;

  logic        is_clk = 1'b0;
  logic        rst_n;
  logic        is_valid;
  logic [19:0] is_data;
  logic        is_sop;
  logic        is_eop;
  logic        is_ready;
  logic        wrreq;
  logic [20:0] wrdata;
  logic        full;
  logic [15:0] ctrl_width;
  logic [15:0] ctrl_height;
  logic [3:0]  ctrl_interlace;
  logic        ctrl_valid;
  logic [15:0] video_frame_count;
  logic [15:0] discard_count;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int cv_cnt   = 0;

  always #5 is_clk = ~is_clk;

  alt_vipcto_is2vid_av_st_input dut (
    .is_clk            (is_clk),
    .rst_n             (rst_n),
    .is_valid          (is_valid),
    .is_data           (is_data),
    .is_sop            (is_sop),
    .is_eop            (is_eop),
    .is_ready          (is_ready),
    .wrreq             (wrreq),
    .wrdata            (wrdata),
    .full              (full),
    .ctrl_width        (ctrl_width),
    .ctrl_height       (ctrl_height),
    .ctrl_interlace    (ctrl_interlace),
    .ctrl_valid        (ctrl_valid),
    .video_frame_count (video_frame_count),
    .discard_count     (discard_count)
  );

  always begin
    @(posedge is_clk);
    #2;
    if (wrreq) wr_cnt++;
    if (ctrl_valid) cv_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hold inputs for one cycle; returns at the next falling edge
  task automatic step(input logic v, input logic [19:0] d,
                      input logic s, input logic e);
    is_valid = v;
    is_data  = d;
    is_sop   = s;
    is_eop   = e;
    @(negedge is_clk);
  endtask

  function automatic logic [19:0] syms(input logic [3:0] s0,
                                       input logic [3:0] s1);
    return {6'd0, s1, 6'd0, s0};
  endfunction

  int wr0;
  int cv0;

  initial begin
    rst_n    = 1'b0;
    is_valid = 1'b0;
    is_data  = '0;
    is_sop   = 1'b0;
    is_eop   = 1'b0;
    full     = 1'b0;
    @(negedge is_clk);
    @(negedge is_clk);
    check("rst_wrreq", 32'(wrreq), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    check("rst_width", 32'(ctrl_width), 32'd0);
    check("rst_height", 32'(ctrl_height), 32'd0);
    check("rst_ilace", 32'(ctrl_interlace), 32'd0);
    check("rst_cvalid", 32'(ctrl_valid), 32'd0);
    check("rst_ready", 32'(is_ready), 32'd1);
    check("rst_vfc", 32'(video_frame_count), 32'd0);
    check("rst_dc", 32'(discard_count), 32'd0);
    rst_n = 1'b1;

    // Control packet: 720x480, interlace 3
    step(1, 20'h0000F, 1, 0);
    step(1, syms(4'h0, 4'h2), 0, 0);
    step(1, syms(4'hD, 4'h0), 0, 0);
    step(1, syms(4'h0, 4'h1), 0, 0);
    step(1, syms(4'hE, 4'h0), 0, 0);
    check("ctl_pre_width", 32'(ctrl_width), 32'd0);
    step(1, syms(4'h3, 4'h0), 0, 1);
    check("ctl_cvalid", 32'(ctrl_valid), 32'd1);
    check("ctl_width", 32'(ctrl_width), 32'h02D0);
    check("ctl_height", 32'(ctrl_height), 32'h01E0);
    check("ctl_ilace", 32'(ctrl_interlace), 32'd3);
    step(0, '0, 0, 0);
    check("ctl_cvalid_drop", 32'(ctrl_valid), 32'd0);
    check("ctl_pulses", 32'(cv_cnt), 32'd1);
    check("ctl_no_write", 32'(wr_cnt), 32'd0);

    // Video packet A..D
    step(1, 20'h00000, 1, 0);
    check("vid_hdr_nowr", 32'(wrreq), 32'd0);
    step(1, 20'h12345, 0, 0);
    check("vid_a_wr", 32'(wrreq), 32'd1);
    check("vid_a_data", 32'(wrdata), 32'h02468A);
    step(1, 20'hABCDE, 0, 0);
    check("vid_b_data", 32'(wrdata), 32'h1579BC);
    step(1, 20'h0F0F0, 0, 0);
    check("vid_c_data", 32'(wrdata), 32'h01E1E0);
    step(1, 20'hFFFFF, 0, 1);
    check("vid_d_wr", 32'(wrreq), 32'd1);
    check("vid_d_data", 32'(wrdata), 32'h1FFFFF);
    step(1, 20'h55555, 0, 0);
    check("vid_idle_drop", 32'(wrreq), 32'd0);
    check("vid_wr_cnt", 32'(wr_cnt), 32'd4);

    // Backpressure: full for 3 cycles, beat E held
    step(1, 20'h00000, 1, 0);
    full     = 1'b1;
    is_valid = 1'b1;
    is_data  = 20'h11111;
    is_sop   = 1'b0;
    is_eop   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_ready", 32'(is_ready), 32'd0);
      @(negedge is_clk);
      check("full_nowr", 32'(wrreq), 32'd0);
    end
    full = 1'b0;
    step(1, 20'h11111, 0, 0);
    check("full_e_data", 32'(wrdata), 32'h022222);
    check("full_e_wr", 32'(wrreq), 32'd1);
    step(1, 20'h22222, 0, 1);
    check("full_f_data", 32'(wrdata), 32'h044445);
    step(0, '0, 0, 0);
    check("full_wr_cnt", 32'(wr_cnt), 32'd6);

    // Truncated control packet leaves ctrl untouched
    cv0 = cv_cnt;
    step(1, 20'h0000F, 1, 0);
    step(1, syms(4'h9, 4'h9), 0, 0);
    step(1, syms(4'h9, 4'h9), 0, 1);
    step(0, '0, 0, 0);
    check("trunc_width", 32'(ctrl_width), 32'h02D0);
    check("trunc_pulses", 32'(cv_cnt), 32'(cv0));

    // Sop mid-video abandons it and starts a 1920x1080 control packet
    step(1, 20'h00000, 1, 0);
    step(1, 20'h33333, 0, 0);
    check("abn_g_data", 32'(wrdata), 32'h066666);
    wr0 = wr_cnt;
    step(1, 20'h0000F, 1, 0);
    check("abn_nowr", 32'(wrreq), 32'd0);
    step(1, syms(4'h0, 4'h7), 0, 0);
    step(1, syms(4'h8, 4'h0), 0, 0);
    step(1, syms(4'h0, 4'h4), 0, 0);
    step(1, syms(4'h3, 4'h8), 0, 0);
    step(1, syms(4'h0, 4'h5), 0, 1);
    check("abn_cvalid", 32'(ctrl_valid), 32'd1);
    check("abn_width", 32'(ctrl_width), 32'h0780);
    check("abn_height", 32'(ctrl_height), 32'h0438);
    check("abn_ilace", 32'(ctrl_interlace), 32'd0);
    step(0, '0, 0, 0);
    check("abn_wr_cnt", 32'(wr_cnt), 32'(wr0));

    // Empty packet then stray beat
    cv0 = cv_cnt;
    step(1, 20'h00000, 1, 1);
    check("empty_nowr", 32'(wrreq), 32'd0);
    step(1, 20'h44444, 0, 0);
    check("empty_idle", 32'(wrreq), 32'd0);
    check("empty_cv", 32'(cv_cnt), 32'(cv0));

    // Ancillary packet, then a one-beat video packet
    wr0 = wr_cnt;
    step(1, 20'h0000D, 1, 0);
    step(1, 20'h00001, 0, 0);
    step(1, 20'h00002, 0, 0);
    step(1, 20'h00003, 0, 1);
    step(0, '0, 0, 0);
    check("anc_nowr", 32'(wr_cnt), 32'(wr0));
    step(1, 20'h00000, 1, 0);
    step(1, 20'h77777, 0, 1);
    check("anc_vid_data", 32'(wrdata), 32'h0EEEEF);
`ifdef AVST_IN_PACKET_COUNTERS_EN
    check("cnt_vfc", 32'(video_frame_count), 32'd3);
    check("cnt_dc", 32'(discard_count), 32'd2);
`else
    check("cnt_vfc", 32'(video_frame_count), 32'd0);
    check("cnt_dc", 32'(discard_count), 32'd0);
`endif

    // Reset mid-video
    step(1, 20'h00000, 1, 0);
    step(1, 20'h12121, 0, 0);
    check("rstm_wr", 32'(wrreq), 32'd1);
    rst_n = 1'b0;
    step(0, '0, 0, 0);
    rst_n = 1'b1;
    check("rstm_wrreq", 32'(wrreq), 32'd0);
    check("rstm_wrdata", 32'(wrdata), 32'd0);
    check("rstm_width", 32'(ctrl_width), 32'd0);
    check("rstm_vfc", 32'(video_frame_count), 32'd0);
    step(1, 20'h23232, 0, 0);
    check("rstm_drop1", 32'(wrreq), 32'd0);
    step(1, 20'h34343, 0, 1);
    check("rstm_drop2", 32'(wrreq), 32'd0);
    check("rstm_ready", 32'(is_ready), 32'd1);
    step(0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
